// File: rtl/computer_pkg.sv
// computer_pkg: shared channel indices, phase generator defaults and step states
package computer_pkg;
   localparam int CH_CPU = 0;
   localparam int CH_MEM = 1;
   localparam int CH_VID = 2;
   localparam logic [23:0] DIV_RST_DEF = {3{8'd49}};
   // ch2..ch0: cpu starts first, memory 12 cycles later, video 25 cycles later
   localparam logic [23:0] PHASE_DEF = {8'd25, 8'd12, 8'd0};
   typedef enum logic {ST_IDLE, ST_BUSY} step_st_t;
endpackage

// File: rtl/phase_chan.sv
// phase_chan: one phase channel with start delay, period counter and shadow divide
module phase_chan #(
   parameter int CNT_W = 8,
   parameter logic [CNT_W-1:0] PHASE = '0,
   parameter logic [CNT_W-1:0] DIV_RST = '0
) (
   input  logic             clock_50,
   input  logic             res,
   input  logic [CNT_W-1:0] div,
   input  logic             hold,
   output logic             phi,
   output logic             rise,
   output logic             at_end
);
   localparam logic [CNT_W:0] START = {1'b0, PHASE} + (CNT_W+1)'(1);
   logic [CNT_W:0] dly;
   logic run, start, wrap;
   logic [CNT_W-1:0] cnt, d, cnt_nx, d_nx;
   assign start = !run && dly == START;
   assign at_end = run && cnt == d;
   // hold parks the counter on its last count instead of wrapping
   assign wrap = at_end && !hold;
   assign d_nx = wrap ? div : d;
   assign cnt_nx = wrap ? '0 : (run && !at_end) ? cnt + CNT_W'(1) : cnt;
   always_ff @(posedge clock_50 or negedge res)
      if (!res) begin
         dly <= '0;
         run <= 1'b0;
         cnt <= '0;
         d <= DIV_RST;
         phi <= 1'b0;
         rise <= 1'b0;
      end else begin
         dly <= (run || start) ? dly : dly + (CNT_W+1)'(1);
         run <= run || start;
         cnt <= cnt_nx;
         d <= d_nx;
         rise <= start || wrap;
         phi <= (run || start) && (cnt_nx <= (d_nx >> 1));
      end
endmodule

// File: rtl/phase_gen.sv
// phase_gen: multi-channel phase generator with cpu single-step and heartbeat
module phase_gen
   import computer_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int CNT_W = 8,
   parameter int HB_W = 23,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_RST = DIV_RST_DEF,
   parameter logic [NUM_CH*CNT_W-1:0] PHASE = PHASE_DEF
) (
   input  logic                    clock_50,
   input  logic                    res,
   input  logic [NUM_CH*CNT_W-1:0] div,
   input  logic                    step_mode,
   input  logic                    step_req,
   output logic [NUM_CH-1:0]       phi,
   output logic [NUM_CH-1:0]       rise,
   output logic                    step_busy,
   output logic                    heartbeat
);
   localparam logic [NUM_CH-1:0] STEP_MASK = NUM_CH'(1) << CH_CPU;
   step_st_t st, st_nx;
   logic [NUM_CH-1:0] at_end;
   logic [HB_W-1:0] hb_cnt;
   logic req_q, cpu_end, start, hold0;
   assign cpu_end = |(at_end & STEP_MASK);
   // a request edge only counts while the cpu channel is parked and idle
   assign start = step_mode && st == ST_IDLE && cpu_end && step_req && !req_q;
   assign hold0 = step_mode && !start;
   assign step_busy = st == ST_BUSY;
   always_comb st_nx = start ? ST_BUSY : (st == ST_BUSY && cpu_end) ? ST_IDLE : st;
   always_ff @(posedge clock_50 or negedge res)
      if (!res) begin
         st <= ST_IDLE;
         req_q <= 1'b0;
         hb_cnt <= '0;
         heartbeat <= 1'b0;
      end else begin
         st <= st_nx;
         req_q <= step_req;
         hb_cnt <= hb_cnt + HB_W'(1);
         heartbeat <= heartbeat ^ (&hb_cnt);
      end
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      phase_chan #(
         .CNT_W  (CNT_W),
         .PHASE  (PHASE[i*CNT_W +: CNT_W]),
         .DIV_RST(DIV_RST[i*CNT_W +: CNT_W])
      ) u_chan (
         .clock_50(clock_50),
         .res     (res),
         .div     (div[i*CNT_W +: CNT_W]),
         .hold    (STEP_MASK[i] && hold0),
         .phi     (phi[i]),
         .rise    (rise[i]),
         .at_end  (at_end[i])
      );
   end
endmodule

// File: tb/tb_phase_gen.sv
// tb_phase_gen: directed scoreboard bench for phase_gen with a short heartbeat counter
module tb_phase_gen;
   localparam int D = 49;
   logic clock_50 = 1'b0;
   logic res = 1'b1;
   logic [23:0] div = {3{8'd49}};
   logic step_mode = 1'b0;
   logic step_req = 1'b0;
   logic [2:0] phi, rise;
   logic step_busy, heartbeat;
   logic [7:0] obs;
   logic [7:0] sb[$];
   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;

   assign obs = {heartbeat, step_busy, rise, phi};
   always #5 clock_50 = ~clock_50;

   phase_gen #(.HB_W(4)) dut (
      .clock_50 (clock_50),
      .res      (res),
      .div      (div),
      .step_mode(step_mode),
      .step_req (step_req),
      .phi      (phi),
      .rise     (rise),
      .step_busy(step_busy),
      .heartbeat(heartbeat)
   );

   // {rise, phi} for a channel whose period of d+1 cycles first starts in cycle c0
   function automatic logic [1:0] per(input int c0, input int d, input int c);
      int k;
      if (c < c0) return 2'b00;
      k = (c - c0) % (d + 1);
      return {k == 0, k < (d + 2) / 2};
   endfunction

   // scen 0: div changes on ch1 and ch0; scen 1: single-step on ch0
   function automatic logic [7:0] exp_at(input int scen, input int c);
      logic [1:0] c0, c1, c2;
      logic busy, hb;
      c2 = per(26, D, c);
      c1 = (scen == 0 && c >= 213) ? per(213, 4, c) : per(13, D, c);
      if (scen == 0) c0 = c >= 251 ? per(251, 0, c) : per(1, D, c);
      else c0 = c <= 150 ? per(1, D, c) : c <= 160 ? 2'b00 : c <= 210 ? per(161, D, c) :
                c <= 230 ? 2'b00 : per(231, D, c);
      busy = scen == 1 && c >= 161 && c <= 210;
      hb = ((c + 1) / 16) % 2 == 1;
      return {hb, busy, c2[1], c1[1], c0[1], c2[0], c1[0], c0[0]};
   endfunction

   task automatic check(input string tag, input logic [7:0] want);
      n_chk++;
      assert (obs === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %b want %b (hb,busy,rise[2:0],phi[2:0])", tag, obs, want);
      end
   endtask

   task automatic run_loop(input int scen, input int n);
      sb.push_back(exp_at(scen, 0));
      for (int c = 0; c < n; c++) begin
         @(posedge clock_50);
         #1;
         check($sformatf("s%0d c%0d", scen, c), sb.pop_front());
         if (scen == 0) begin
            if (c == 173) div[15:8] = 8'd4;
            if (c == 240) div[7:0] = 8'd0;
         end else begin
            if (c == 120) step_mode = 1'b1;
            if (c == 160 || c == 181) step_req = 1'b1;
            if (c == 162 || c == 183) step_req = 1'b0;
            if (c == 230) step_mode = 1'b0;
         end
         if (c < n - 1) sb.push_back(exp_at(scen, c + 1));
      end
   endtask

   initial begin
      #2 res = 1'b0;
      repeat (3) @(posedge clock_50);
      #1 check("reset", 8'h00);
      res = 1'b1;
      run_loop(0, 263);
      #2 res = 1'b0;
      #1 check("async abort", 8'h00);
      div = {3{8'd49}};
      repeat (3) @(posedge clock_50);
      #1 check("held in reset", 8'h00);
      res = 1'b1;
      run_loop(1, 32);
      #2 res = 1'b0;
      #1 check("abort at cnt30", 8'h00);
      @(posedge clock_50);
      #1 res = 1'b1;
      run_loop(1, 261);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "timeout");
   end
endmodule
